// File: rtl/result_display_seq_if.sv
// rtl/result_display_seq_if.sv - result write bus and display bus bundle
// Purpose: groups the result capture signals (res_*) and the display
// outputs (disp_*) of result_display_seq.
// Modports:
//   slave  - the sequencer: consumes res_*, drives disp_*
//   master - the result producer / display consumer: drives res_*, reads disp_*
interface result_display_seq_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2,
    parameter int OUT_W  = 8,
    parameter int SL_W   = 1
);
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;
    logic [OUT_W-1:0]  disp_data;
    logic [CH_W-1:0]   disp_ch;
    logic [SL_W-1:0]   disp_slice;
    logic              disp_strobe;

    modport master (
        output res_valid, res_ch, res_data,
        input  disp_data, disp_ch, disp_slice, disp_strobe
    );

    modport slave (
        input  res_valid, res_ch, res_data,
        output disp_data, disp_ch, disp_slice, disp_strobe
    );
endinterface

// File: rtl/result_display_seq.sv
// rtl/result_display_seq.sv - multi-channel result capture and sliced LED display sequencer
// Purpose: holds the latest result per channel and steps through every
// channel and OUT_W-bit slice (MS slice first) at a DWELL_CYCLES rate,
// snapshotting each channel once per pass so its slices never tear.
// Optional feature macro: RESULT_DISPLAY_PEAK_HOLD_EN (peak hold between snapshots).
// Ports:
//   sys_clk  - system clock
//   rst      - synchronous active-high reset
//   en       - sequencer run enable
//   freeze   - hold the display, capture continues
//   bus      - res_valid/res_ch/res_data in, disp_data/disp_ch/disp_slice/disp_strobe out
//   overrun  - sticky: result overwritten before it was displayed
//   bad_ch   - sticky: write to an out-of-range channel
module result_display_seq #(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 4,
    parameter int OUT_W        = 8,
    parameter int DWELL_CYCLES = 65536
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 freeze,
    result_display_seq_if.slave  bus,
    output logic                 overrun,
    output logic                 bad_ch
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NUM_SL = (DATA_W + OUT_W - 1) / OUT_W;
    localparam int SL_W   = (NUM_SL > 1) ? $clog2(NUM_SL) : 1;
    localparam int PAD_W  = NUM_SL * OUT_W;
    localparam int CNT_W  = $clog2(DWELL_CYCLES);

    localparam logic [SL_W-1:0]  SL_LAST  = SL_W'(NUM_SL - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EMIT
    } phase_e;

    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [PAD_W-1:0]  snap_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CH_W-1:0]   seq_ch_q;
    logic [SL_W-1:0]   seq_sl_q;
    logic [OUT_W-1:0]  disp_data_q;
    logic [CH_W-1:0]   disp_ch_q;
    logic [SL_W-1:0]   disp_slice_q;
    logic              disp_strobe_q;
    logic              overrun_q;
    logic              bad_ch_q;

    phase_e            phase;
    logic              ch_oob;
    logic              snap_hit;
    logic [PAD_W-1:0]  cur_pad;
    logic [DATA_W-1:0] wr_value;

    always_comb begin
        phase = ST_IDLE;
        if (en && !freeze) begin
            phase = (cnt_q == CNT_LAST) ? ST_EMIT : ST_RUN;
        end
    end

    assign ch_oob   = ({1'b0, bus.res_ch} >= (CH_W + 1)'(NUM_CH));
    // A write landing on the snapshot edge of its own channel: the snapshot
    // consumes the old value, so the write starts a fresh pending interval.
    assign snap_hit = (phase == ST_EMIT) && (seq_sl_q == SL_LAST) && (seq_ch_q == bus.res_ch);
    // Zero-extend so the top slice reads 0 above DATA_W.
    assign cur_pad  = PAD_W'(shadow_q[seq_ch_q]);

`ifdef RESULT_DISPLAY_PEAK_HOLD_EN
    logic [DATA_W-1:0] old_value;
    assign old_value = shadow_q[bus.res_ch];
    assign wr_value  = (pending_q[bus.res_ch] && !snap_hit && (old_value > bus.res_data))
                       ? old_value : bus.res_data;
`else
    assign wr_value  = bus.res_data;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
            pending_q     <= '0;
            snap_q        <= '0;
            cnt_q         <= '0;
            seq_ch_q      <= '0;
            seq_sl_q      <= SL_LAST;
            disp_data_q   <= '0;
            disp_ch_q     <= '0;
            disp_slice_q  <= '0;
            disp_strobe_q <= 1'b0;
            overrun_q     <= 1'b0;
            bad_ch_q      <= 1'b0;
        end else begin
            case (phase)
                ST_IDLE: begin
                    cnt_q         <= '0;
                    disp_strobe_q <= 1'b0;
                end
                ST_RUN: begin
                    cnt_q         <= cnt_q + 1'b1;
                    disp_strobe_q <= 1'b0;
                end
                default: begin
                    cnt_q         <= '0;
                    disp_strobe_q <= 1'b1;
                    disp_ch_q     <= seq_ch_q;
                    disp_slice_q  <= seq_sl_q;
                    if (seq_sl_q == SL_LAST) begin
                        // Top slice comes straight from shadow; snap serves the rest of the channel.
                        snap_q              <= cur_pad;
                        pending_q[seq_ch_q] <= 1'b0;
                        disp_data_q         <= cur_pad[(NUM_SL - 1) * OUT_W +: OUT_W];
                    end else begin
                        disp_data_q <= snap_q[int'(seq_sl_q) * OUT_W +: OUT_W];
                    end
                    if (seq_sl_q == '0) begin
                        seq_sl_q <= SL_LAST;
                        seq_ch_q <= (seq_ch_q == CH_LAST) ? '0 : seq_ch_q + 1'b1;
                    end else begin
                        seq_sl_q <= seq_sl_q - 1'b1;
                    end
                end
            endcase

            // Capture follows the snapshot so a same-edge write leaves pending set.
            if (bus.res_valid) begin
                if (ch_oob) begin
                    bad_ch_q <= 1'b1;
                end else begin
                    if (pending_q[bus.res_ch] && !snap_hit) begin
                        overrun_q <= 1'b1;
                    end
                    shadow_q[bus.res_ch]  <= wr_value;
                    pending_q[bus.res_ch] <= 1'b1;
                end
            end
        end
    end

    assign bus.disp_data   = disp_data_q;
    assign bus.disp_ch     = disp_ch_q;
    assign bus.disp_slice  = disp_slice_q;
    assign bus.disp_strobe = disp_strobe_q;
    assign overrun         = overrun_q;
    assign bad_ch          = bad_ch_q;
endmodule
